ecc_scalar_mult_ctrl: RTL and testbench

Left-to-right double-and-add sequencer that computes Q = k·P over a prime-field Weierstrass curve. It sits directly downstream of the point_doubling and point_addition units, which are instantiated beside it at the top level. It issues one operation at a time to either unit, consumes each result, and keeps the running accumulator Q. It also handles the point-at-infinity and operand-equality cases that the arithmetic units do not handle.

---
 rtl/ecc_pkg.sv | 18 +
 rtl/ecc_scalar_mult_ctrl_msb_index.sv | 22 ++
 rtl/ecc_scalar_mult_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ecc_scalar_mult_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared types for the elliptic-curve scalar multiplication controller.
package ecc_pkg;

    localparam int N_DEFAULT = 231;

    typedef enum logic [3:0] {
        IDLE,
        SCAN,
        DBL_REQ,
        DBL_WAIT,
        CHK,
        ADD_REQ,
        ADD_WAIT,
        NEXT,
        FIN
    } state_t;

endpackage

// File: rtl/ecc_scalar_mult_ctrl_msb_index.sv
// Priority encoder: index of the most-significant set bit, plus an all-zero flag.
module msb_index #(
    parameter int N  = 231,
    parameter int CW = $clog2(N)
) (
    input  logic [N-1:0]  v,
    output logic [CW-1:0] j,
    output logic          zero
);

    always_comb begin
        j = '0;
        for (int b = 0; b < N; b++) begin
            if (v[b]) begin
                j = CW'(b);
            end
        end
    end

    assign zero = ~|v;

endmodule

// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer driving external point doubling and
// point addition units; resolves infinity and equal-x cases locally.
module ecc_scalar_mult_ctrl
    import ecc_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] k,
    input  logic [N-1:0] px,
    input  logic [N-1:0] py,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] qx,
    output logic [N-1:0] qy,
    output logic         q_inf,
    output logic         dbl_start,
    output logic [N-1:0] dbl_x,
    output logic [N-1:0] dbl_y,
    input  logic         dbl_done,
    input  logic [N-1:0] dbl_x3,
    input  logic [N-1:0] dbl_y3,
    input  logic         dbl_inf,
    output logic         add_start,
    output logic [N-1:0] add_x1,
    output logic [N-1:0] add_y1,
    output logic [N-1:0] add_x2,
    output logic [N-1:0] add_y2,
    input  logic         add_done,
    input  logic [N-1:0] add_x3,
    input  logic [N-1:0] add_y3,
    input  logic         add_inf
);

    state_t        state_q, state_d;
    logic [N-1:0]  kr_q, kr_d;
    logic [N-1:0]  pxr_q, pxr_d;
    logic [N-1:0]  pyr_q, pyr_d;
    logic [N-1:0]  qxr_q, qxr_d;
    logic [N-1:0]  qyr_q, qyr_d;
    logic          qinf_q, qinf_d;
    logic [CW-1:0] i_q, i_d;
    logic          ret_next_q, ret_next_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  qx_q, qx_d;
    logic [N-1:0]  qy_q, qy_d;
    logic          q_inf_q, q_inf_d;
    logic          dbl_start_q, dbl_start_d;
    logic [N-1:0]  dbl_x_q, dbl_x_d;
    logic [N-1:0]  dbl_y_q, dbl_y_d;
    logic          add_start_q, add_start_d;
    logic [N-1:0]  add_x1_q, add_x1_d;
    logic [N-1:0]  add_y1_q, add_y1_d;
    logic [N-1:0]  add_x2_q, add_x2_d;
    logic [N-1:0]  add_y2_q, add_y2_d;

    logic [CW-1:0] msb_j;
    logic          k_zero;

    msb_index #(.N(N), .CW(CW)) u_msb_index (
        .v    (kr_q),
        .j    (msb_j),
        .zero (k_zero)
    );

    always_comb begin
        state_d     = state_q;
        kr_d        = kr_q;
        pxr_d       = pxr_q;
        pyr_d       = pyr_q;
        qxr_d       = qxr_q;
        qyr_d       = qyr_q;
        qinf_d      = qinf_q;
        i_d         = i_q;
        ret_next_d  = ret_next_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        qx_d        = qx_q;
        qy_d        = qy_q;
        q_inf_d     = q_inf_q;
        dbl_start_d = 1'b0;
        dbl_x_d     = dbl_x_q;
        dbl_y_d     = dbl_y_q;
        add_start_d = 1'b0;
        add_x1_d    = add_x1_q;
        add_y1_d    = add_y1_q;
        add_x2_d    = add_x2_q;
        add_y2_d    = add_y2_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    kr_d    = k;
                    pxr_d   = px;
                    pyr_d   = py;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                ret_next_d = 1'b0;
                if (k_zero) begin
                    // Zero scalar finishes straight from here, one cycle ahead of FIN.
                    qinf_d  = 1'b1;
                    qx_d    = '0;
                    qy_d    = '0;
                    q_inf_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    qxr_d  = pxr_q;
                    qyr_d  = pyr_q;
                    qinf_d = 1'b0;
                    if (msb_j == '0) begin
                        state_d = FIN;
                    end else begin
                        i_d     = msb_j - CW'(1);
                        state_d = DBL_REQ;
                    end
                end
            end
            DBL_REQ: begin
                ret_next_d = 1'b0;
                if (qinf_q) begin
                    state_d = CHK;
                end else if (qyr_q == '0) begin
                    qinf_d  = 1'b1;
                    state_d = CHK;
                end else begin
                    dbl_start_d = 1'b1;
                    dbl_x_d     = qxr_q;
                    dbl_y_d     = qyr_q;
                    state_d     = DBL_WAIT;
                end
            end
            DBL_WAIT: begin
                if (dbl_done) begin
                    qxr_d   = dbl_x3;
                    qyr_d   = dbl_y3;
                    qinf_d  = dbl_inf;
                    state_d = ret_next_q ? NEXT : CHK;
                end
            end
            CHK: begin
                state_d = kr_q[i_q] ? ADD_REQ : NEXT;
            end
            ADD_REQ: begin
                if (qinf_q) begin
                    qxr_d   = pxr_q;
                    qyr_d   = pyr_q;
                    qinf_d  = 1'b0;
                    state_d = NEXT;
                end else if (qxr_q == pxr_q) begin
                    if (qyr_q != pyr_q || qyr_q == '0) begin
                        // Q = -P, or Q = P with a vertical tangent.
                        qinf_d  = 1'b1;
                        state_d = NEXT;
                    end else begin
                        // Q = P: the adder cannot take equal operands, so double instead.
                        dbl_start_d = 1'b1;
                        dbl_x_d     = qxr_q;
                        dbl_y_d     = qyr_q;
                        ret_next_d  = 1'b1;
                        state_d     = DBL_WAIT;
                    end
                end else begin
                    add_start_d = 1'b1;
                    add_x1_d    = qxr_q;
                    add_y1_d    = qyr_q;
                    add_x2_d    = pxr_q;
                    add_y2_d    = pyr_q;
                    state_d     = ADD_WAIT;
                end
            end
            ADD_WAIT: begin
                if (add_done) begin
                    qxr_d   = add_x3;
                    qyr_d   = add_y3;
                    qinf_d  = add_inf;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (i_q == '0) begin
                    state_d = FIN;
                end else begin
                    i_d     = i_q - CW'(1);
                    state_d = DBL_REQ;
                end
            end
            FIN: begin
                qx_d    = qinf_q ? '0 : qxr_q;
                qy_d    = qinf_q ? '0 : qyr_q;
                q_inf_d = qinf_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            kr_q        <= '0;
            pxr_q       <= '0;
            pyr_q       <= '0;
            qxr_q       <= '0;
            qyr_q       <= '0;
            qinf_q      <= 1'b0;
            i_q         <= '0;
            ret_next_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            qx_q        <= '0;
            qy_q        <= '0;
            q_inf_q     <= 1'b0;
            dbl_start_q <= 1'b0;
            dbl_x_q     <= '0;
            dbl_y_q     <= '0;
            add_start_q <= 1'b0;
            add_x1_q    <= '0;
            add_y1_q    <= '0;
            add_x2_q    <= '0;
            add_y2_q    <= '0;
        end else begin
            state_q     <= state_d;
            kr_q        <= kr_d;
            pxr_q       <= pxr_d;
            pyr_q       <= pyr_d;
            qxr_q       <= qxr_d;
            qyr_q       <= qyr_d;
            qinf_q      <= qinf_d;
            i_q         <= i_d;
            ret_next_q  <= ret_next_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            qx_q        <= qx_d;
            qy_q        <= qy_d;
            q_inf_q     <= q_inf_d;
            dbl_start_q <= dbl_start_d;
            dbl_x_q     <= dbl_x_d;
            dbl_y_q     <= dbl_y_d;
            add_start_q <= add_start_d;
            add_x1_q    <= add_x1_d;
            add_y1_q    <= add_y1_d;
            add_x2_q    <= add_x2_d;
            add_y2_q    <= add_y2_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign qx        = qx_q;
    assign qy        = qy_q;
    assign q_inf     = q_inf_q;
    assign dbl_start = dbl_start_q;
    assign dbl_x     = dbl_x_q;
    assign dbl_y     = dbl_y_q;
    assign add_start = add_start_q;
    assign add_x1    = add_x1_q;
    assign add_y1    = add_y1_q;
    assign add_x2    = add_x2_q;
    assign add_y2    = add_y2_q;

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Directed bench on y^2 = x^3 + 2x + 2 mod 17, G = (5,1), with random-latency
// behavioural doubling/addition units and a queue of expected results.
module tb_ecc_scalar_mult_ctrl;

    localparam int N = 231;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [N-1:0] k, px, py;
    logic         busy, done, q_inf;
    logic [N-1:0] qx, qy;
    logic         dbl_start, dbl_done, dbl_inf;
    logic [N-1:0] dbl_x, dbl_y, dbl_x3, dbl_y3;
    logic         add_start, add_done, add_inf;
    logic [N-1:0] add_x1, add_y1, add_x2, add_y2, add_x3, add_y3;

    ecc_scalar_mult_ctrl #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .k(k), .px(px), .py(py),
        .busy(busy), .done(done), .qx(qx), .qy(qy), .q_inf(q_inf),
        .dbl_start(dbl_start), .dbl_x(dbl_x), .dbl_y(dbl_y),
        .dbl_done(dbl_done), .dbl_x3(dbl_x3), .dbl_y3(dbl_y3), .dbl_inf(dbl_inf),
        .add_start(add_start), .add_x1(add_x1), .add_y1(add_y1),
        .add_x2(add_x2), .add_y2(add_y2),
        .add_done(add_done), .add_x3(add_x3), .add_y3(add_y3), .add_inf(add_inf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit inf;
        int ndbl;
        int nadd;
        int ncyc;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int dbl_pulses = 0;
    int add_pulses = 0;
    int both_pulses = 0;

    function automatic int md(input int a);
        return ((a % 17) + 17) % 17;
    endfunction

    function automatic int inv(input int a);
        for (int b = 1; b < 17; b++) begin
            if (md(a * b) == 1) return b;
        end
        return 0;
    endfunction

    // Unit models: tangent and chord formulas, a = 2
    int dbl_lat = 0, add_lat = 0;
    bit dbl_pend = 1'b0, add_pend = 1'b0;
    int dx, dy, ax1, ay1, ax2, ay2;

    always @(posedge clk) begin
        int l, x3, y3;
        dbl_done <= 1'b0;
        if (dbl_start) begin
            dbl_pend <= 1'b1;
            dbl_lat  <= int'($urandom_range(20, 1));
            dx       <= int'(dbl_x[7:0]);
            dy       <= int'(dbl_y[7:0]);
        end else if (dbl_pend) begin
            if (dbl_lat <= 1) begin
                l  = md((3 * dx * dx + 2) * inv(md(2 * dy)));
                x3 = md(l * l - 2 * dx);
                y3 = md(l * (dx - x3) - dy);
                dbl_x3   <= {{(N-8){1'b0}}, 8'(x3)};
                dbl_y3   <= {{(N-8){1'b0}}, 8'(y3)};
                dbl_inf  <= (dy == 0);
                dbl_done <= 1'b1;
                dbl_pend <= 1'b0;
            end else begin
                dbl_lat <= dbl_lat - 1;
            end
        end
    end

    always @(posedge clk) begin
        int l, x3, y3;
        add_done <= 1'b0;
        if (add_start) begin
            add_pend <= 1'b1;
            add_lat  <= int'($urandom_range(20, 1));
            ax1 <= int'(add_x1[7:0]);
            ay1 <= int'(add_y1[7:0]);
            ax2 <= int'(add_x2[7:0]);
            ay2 <= int'(add_y2[7:0]);
        end else if (add_pend) begin
            if (add_lat <= 1) begin
                l  = md((ay2 - ay1) * inv(md(ax2 - ax1)));
                x3 = md(l * l - ax1 - ax2);
                y3 = md(l * (ax1 - x3) - ay1);
                add_x3   <= {{(N-8){1'b0}}, 8'(x3)};
                add_y3   <= {{(N-8){1'b0}}, 8'(y3)};
                add_inf  <= (ax1 == ax2);
                add_done <= 1'b1;
                add_pend <= 1'b0;
            end else begin
                add_lat <= add_lat - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (dbl_start) dbl_pulses <= dbl_pulses + 1;
        if (add_start) add_pulses <= add_pulses + 1;
        if (dbl_start && add_start) both_pulses <= both_pulses + 1;
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Run one multiplication of G; optionally re-pulse start (k=1) at cycle rs while busy.
    task automatic run_k(input int kv, input int ex, input int ey, input bit einf,
                         input int edbl, input int eadd, input int ecyc, input int rs);
        exp_t e;
        int d0, a0, cyc;
        e.x = ex; e.y = ey; e.inf = einf; e.ndbl = edbl; e.nadd = eadd; e.ncyc = ecyc;
        sb.push_back(e);
        d0 = dbl_pulses;
        a0 = add_pulses;
        k = N'(kv); px = N'(5); py = N'(1);
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == rs) begin
                start = 1'b1;
                k = N'(1);
            end else begin
                start = 1'b0;
            end
        end while (!done && cyc < 3000);
        start = 1'b0;
        chk($sformatf("k%0d_done_seen", kv), N'(done), N'(1));
        e = sb.pop_front();
        chk($sformatf("k%0d_qx", kv), qx, N'(e.x));
        chk($sformatf("k%0d_qy", kv), qy, N'(e.y));
        chk($sformatf("k%0d_qinf", kv), N'(q_inf), N'(e.inf));
        chk($sformatf("k%0d_busy_at_done", kv), N'(busy), N'(0));
        if (e.ncyc > 0) chk($sformatf("k%0d_latency", kv), N'(cyc), N'(e.ncyc));
        @(negedge clk);
        chk($sformatf("k%0d_dbl_pulses", kv), N'(dbl_pulses - d0), N'(e.ndbl));
        chk($sformatf("k%0d_add_pulses", kv), N'(add_pulses - a0), N'(e.nadd));
        chk($sformatf("k%0d_done_one_cycle", kv), N'(done), N'(0));
        chk($sformatf("k%0d_qx_held", kv), qx, N'(e.x));
        $display("[TB] k=%0d -> (%0d,%0d) inf=%0d after %0d cycles", kv, qx, qy, q_inf, cyc);
    endtask

    initial begin
        int cyc;
        bit saw_done;
        reset = 1'b1; start = 1'b0; k = '0; px = '0; py = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", N'(busy), N'(0));
        chk("rst_done", N'(done), N'(0));
        chk("rst_qx", qx, N'(0));
        chk("rst_dbl_start", N'(dbl_start), N'(0));
        reset = 1'b0;
        @(negedge clk);

        run_k(1, 5, 1, 1'b0, 0, 0, 3, 0);
        run_k(2, 6, 3, 1'b0, 1, 0, 0, 0);
        run_k(5, 9, 16, 1'b0, 2, 1, 0, 0);
        run_k(19, 0, 0, 1'b1, 4, 1, 0, 0);
        run_k(0, 0, 0, 1'b1, 0, 0, 2, 0);
        run_k(5, 9, 16, 1'b0, 2, 1, 0, 6);

        // Abort in DBL_WAIT
        k = N'(5); px = N'(5); py = N'(1);
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end while (!dbl_start && cyc < 100);
        chk("abort_dbl_seen", N'(dbl_start), N'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", N'(busy), N'(0));
        chk("abort_qx", qx, N'(0));
        chk("abort_qy", qy, N'(0));
        chk("abort_qinf", N'(q_inf), N'(0));
        chk("abort_dbl_start", N'(dbl_start), N'(0));
        chk("abort_dbl_x", dbl_x, N'(0));
        chk("abort_add_x1", add_x1, N'(0));
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort_no_done", N'(saw_done), N'(0));
        $display("[TB] reset during DBL_WAIT: outputs cleared, idle for 30 cycles");

        run_k(3, 10, 6, 1'b0, 1, 1, 0, 0);

        chk("never_both_starts", N'(both_pulses), N'(0));
        chk("scoreboard_empty", N'(sb.size()), N'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
